// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
// The PARITY state exists only when SIPO_PARITY_EN is defined.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles MSB-first frames into d with a one-cycle load pulse.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_valid,
  input  logic             ser_in,
  input  logic             ser_start,
  input  logic             err_clr,
  output logic             load,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             load_reg, load_next;
  logic             err_reg, err_next;
  logic             err_set;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;

  assign shifted   = {shift_reg[WIDTH-2:0], ser_in};
  assign first_bit = {{(WIDTH-1){1'b0}}, ser_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      d_reg     <= '0;
      count_reg <= '0;
      load_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      d_reg     <= d_next;
      count_reg <= count_next;
      load_reg  <= load_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    d_next     = d_reg;
    count_next = count_reg;
    load_next  = 1'b0;
    err_set    = 1'b0;

    case (state_reg)
      IDLE: begin
        // Also taken in the cycle load is high, so frames can run back-to-back.
        if (ser_valid && ser_start) begin
          shift_next = first_bit;
          count_next = CNT_ONE;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (ser_valid) begin
          if (ser_start) begin
            err_set    = 1'b1;
            shift_next = first_bit;
            count_next = CNT_ONE;
          end else if (count_reg == CNT_LAST) begin
`ifdef SIPO_PARITY_EN
            shift_next = shifted;
            count_next = CNT_FULL;
            state_next = PARITY;
`else
            d_next     = shifted;
            load_next  = 1'b1;
            shift_next = '0;
            count_next = '0;
            state_next = IDLE;
`endif
          end else begin
            shift_next = shifted;
            count_next = count_reg + CNT_ONE;
          end
        end
      end

`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (ser_valid) begin
          if (ser_start) begin
            err_set    = 1'b1;
            shift_next = first_bit;
            count_next = CNT_ONE;
            state_next = SHIFT;
          end else begin
            // Even parity: the trailer bit equals the XOR of the word bits.
            if (ser_in == ^shift_reg) begin
              d_next    = shift_reg;
              load_next = 1'b1;
            end else begin
              err_set = 1'b1;
            end
            shift_next = '0;
            count_next = '0;
            state_next = IDLE;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
        shift_next = '0;
        count_next = '0;
      end
    endcase

    // A fresh error in the same cycle as err_clr keeps the flag set.
    if (err_set) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  assign load      = load_reg;
  assign d         = d_reg;
  assign busy      = (state_reg != IDLE);
  assign frame_err = err_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed vector table, hand sequences, random vs model.
// Build with SIPO_PARITY_EN defined to exercise the parity variant.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_start = 1'b0;
  logic         err_clr = 1'b0;
  logic         load;
  logic [W-1:0] d;
  logic         busy;
  logic         frame_err;

  int total = 0;
  int bad   = 0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_valid (ser_valid),
    .ser_in    (ser_in),
    .ser_start (ser_start),
    .err_clr   (err_clr),
    .load      (load),
    .d         (d),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r, v, s, b, c;
    logic         e_load, e_busy, e_err;
    logic [W-1:0] e_d;
    string        tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic r, v, s, b, c,
                     input logic el, eb, ee, input logic [W-1:0] ed);
    vec_t x;
    x.tag = tag; x.r = r; x.v = v; x.s = s; x.b = b; x.c = c;
    x.e_load = el; x.e_busy = eb; x.e_err = ee; x.e_d = ed;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, v, s, b, c);
    rst = r; ser_valid = v; ser_start = s; ser_in = b; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic el, eb, ee, input logic [W-1:0] ed);
    chk({tag, ".load"}, 32'(load), 32'(el));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".err"},  32'(frame_err), 32'(ee));
    chk({tag, ".d"},    32'(d), 32'(ed));
    $display("txn %s: load=%0b busy=%0b err=%0b d=%b", tag, load, busy, frame_err, d);
  endtask

  // Reference model: collects frame bits in a queue and emits words by rule.
  bit           mq[$];
  bit           m_in;
  logic [W-1:0] m_d;
  bit           m_load, m_err;

  function automatic logic [W-1:0] pack_q();
    logic [W-1:0] w = '0;
    foreach (mq[i]) w = {w[W-2:0], mq[i]};
    return w;
  endfunction

  task automatic model_step(input logic r, v, s, b, c);
    bit new_err = 1'b0;
    if (r) begin
      mq.delete(); m_in = 0; m_d = '0; m_load = 0; m_err = 0;
      return;
    end
    m_load = 0;
    if (v) begin
      if (s) begin
        if (m_in) new_err = 1'b1;
        mq.delete(); mq.push_back(b); m_in = 1;
      end else if (m_in) begin
        if (mq.size() == W) begin
          if (b == ^pack_q()) begin m_d = pack_q(); m_load = 1; end
          else new_err = 1'b1;
          mq.delete(); m_in = 0;
        end else begin
          mq.push_back(b);
`ifndef SIPO_PARITY_EN
          if (mq.size() == W) begin
            m_d = pack_q(); m_load = 1; mq.delete(); m_in = 0;
          end
`endif
        end
      end
    end
    m_err = new_err ? 1'b1 : (c ? 1'b0 : m_err);
  endtask

  initial begin
    // ---- directed vector table: {rst,valid,start,bit,clr} -> {load,busy,err,d}
    for (int i = 0; i < 10; i++) add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
`ifndef SIPO_PARITY_EN
    add("frm_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b0000);
    add("frm_b2", 0, 1, 0, 0, 0, 0, 1, 0, 4'b0000);
    add("frm_b3", 0, 1, 0, 1, 0, 0, 1, 0, 4'b0000);
    add("frm_b4", 0, 1, 0, 0, 0, 1, 0, 0, 4'b1010);
    add("frm_id", 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010);
    add("stl_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b1010);
    add("stl_b2", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1010);
    for (int i = 0; i < 3; i++) add("stl_w", 0, 0, 0, 1, 0, 0, 1, 0, 4'b1010);
    add("stl_b3", 0, 1, 0, 0, 0, 0, 1, 0, 4'b1010);
    add("stl_b4", 0, 1, 0, 0, 0, 1, 0, 0, 4'b1100);
    add("stl_id", 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100);
    add("b2b_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b1100);
    add("b2b_b2", 0, 1, 0, 0, 0, 0, 1, 0, 4'b1100);
    add("b2b_b3", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1100);
    add("b2b_b4", 0, 1, 0, 0, 0, 1, 0, 0, 4'b1010);
    add("b2b_s2", 0, 1, 1, 0, 0, 0, 1, 0, 4'b1010);
    add("b2b_c2", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1010);
    add("b2b_c3", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1010);
    add("b2b_c4", 0, 1, 0, 0, 0, 1, 0, 0, 4'b0110);
    add("b2b_id", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    add("abt_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b0110);
    add("abt_b2", 0, 1, 0, 1, 0, 0, 1, 0, 4'b0110);
    add("abt_rs", 0, 1, 1, 0, 0, 0, 1, 1, 4'b0110);
    add("abt_b2", 0, 1, 0, 0, 0, 0, 1, 1, 4'b0110);
    add("abt_b3", 0, 1, 0, 1, 0, 0, 1, 1, 4'b0110);
    add("abt_b4", 0, 1, 0, 1, 0, 1, 0, 1, 4'b0011);
    add("abt_cl", 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011);
    add("idl_ns", 0, 1, 0, 1, 0, 0, 0, 0, 4'b0011);
`else
    add("par_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b0000);
    add("par_b2", 0, 1, 0, 0, 0, 0, 1, 0, 4'b0000);
    add("par_b3", 0, 1, 0, 1, 0, 0, 1, 0, 4'b0000);
    add("par_b4", 0, 1, 0, 1, 0, 0, 1, 0, 4'b0000);
    add("par_ok", 0, 1, 0, 1, 0, 1, 0, 0, 4'b1011);
    add("par_s",  0, 1, 1, 1, 0, 0, 1, 0, 4'b1011);
    add("par_b2", 0, 1, 0, 0, 0, 0, 1, 0, 4'b1011);
    add("par_b3", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1011);
    add("par_b4", 0, 1, 0, 1, 0, 0, 1, 0, 4'b1011);
    add("par_bd", 0, 1, 0, 0, 0, 0, 0, 1, 4'b1011);
    add("par_id", 0, 0, 0, 0, 0, 0, 0, 1, 4'b1011);
    add("par_cl", 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].b, vecs[i].c);
      chk_all(vecs[i].tag, vecs[i].e_load, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_d);
    end

    // ---- hand sequence: a new error beats err_clr in the same cycle
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 0, 1);
    chk_all("err_win", 0, 1, 1, vecs[vecs.size()-1].e_d);

    // ---- hand sequence: reset mid-frame wins over a simultaneous start
    step(0, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    chk_all("rst_mid", 0, 0, 0, 4'b0000);
    step(0, 1, 0, 1, 0);
    chk_all("rst_idl", 0, 0, 0, 4'b0000);

    // ---- randomized stimulus against the reference model
    step(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, v, s, b, c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      b = 1'($urandom);
      c = ($urandom_range(0, 19) == 0);
      step(r, v, s, b, c);
      model_step(r, v, s, b, c);
      chk("rnd.load", 32'(load), 32'(m_load));
      chk("rnd.busy", 32'(busy), 32'(m_in));
      chk("rnd.err",  32'(frame_err), 32'(m_err));
      chk("rnd.d",    32'(d), 32'(m_d));
      if (m_load) $display("txn rnd word: d=%b err=%0b", d, frame_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter: WIDTH, 4, assembled word width; legal range 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: ser_valid  input  1  the serial bit on ser_in is presented this cycle.
REQ-005 Port: ser_in  input  1  serial data bit; MSB first.
REQ-006 Port: ser_start  input  1  marks the first bit of a frame; ignored unless ser_valid=1.
REQ-007 Port: err_clr  input  1  clears frame_err.
REQ-008 Port: load  output  1  one-cycle pulse: d holds a new complete word; drives the downstream register's load.
REQ-009 Port: d  output  WIDTH  last complete word; stable between load pulses.
REQ-010 Port: busy  output  1  high while a frame is partially received.
REQ-011 Port: frame_err  output  1  sticky framing/parity error flag.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-013 In IDLE, ser_valid=1 with ser_start=1 SHALL shift ser_in into the shift register, set bit count to 1, and move to SHIFT.
REQ-014 In IDLE, ser_valid=1 with ser_start=0 SHALL be discarded with no state change.
REQ-015 In SHIFT, each ser_valid=1 cycle SHALL shift ser_in in at the LSB and increment the count; ser_valid=0 cycles SHALL hold all state.
REQ-016 When bit WIDTH is accepted without parity compiled in, the next edge SHALL copy the word to d, pulse load for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be one cycle: load is high in the cycle after the last bit is sampled.
REQ-018 In that completing cycle, load SHALL coincide with acceptance of a new start bit, allowing back-to-back frames with no gap.
REQ-019 ser_start=1 with ser_valid=1 in SHIFT or PARITY SHALL set frame_err, discard the partial word, and restart the frame with the current bit as bit 1; load SHALL NOT pulse.
REQ-020 busy SHALL be high exactly when the state is SHIFT or PARITY.
REQ-021 err_clr=1 SHALL clear frame_err on the next edge; a new error in the same cycle SHALL win.
REQ-022 The shift register and count SHALL NOT wrap; the count saturates at WIDTH and SHALL be cleared on exit.

Reset
REQ-023 While rst=1, the next edge SHALL set the state to IDLE, and load, busy and frame_err to 0.
REQ-024 While rst=1, the next edge SHALL clear d, the shift register and the count to 0.
REQ-025 rst mid-frame SHALL discard the partial word with no load pulse; rst SHALL take priority over all inputs.

Configuration
REQ-026 With SIPO_PARITY_EN defined, after bit WIDTH the FSM SHALL enter PARITY, and the next valid bit SHALL be an even-parity bit over the word.
REQ-027 With SIPO_PARITY_EN defined, a parity match SHALL load per REQ-016.
REQ-028 With SIPO_PARITY_EN defined, a parity mismatch SHALL set frame_err, return to IDLE and suppress load, leaving d unchanged.
REQ-029 Without SIPO_PARITY_EN, the PARITY state and its logic SHALL be absent, and behaviour SHALL match REQ-016.

Structure
REQ-030 A shared package sipo_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-031 The design SHALL be a single module with no sub-modules; the bit counter stays inline.

Verification
REQ-032 Reset: rst=1 for 10 cycles, then 0 -> d=0000, load=0, busy=0, frame_err=0.
REQ-033 Frame: start+bits 1,0,1,0 on consecutive cycles -> load pulses once, one cycle after the last bit, with d=1010; busy=0 afterwards.
REQ-034 Stall: bits 1,1,0,0 with ser_valid=0 for 3 cycles between bits 2 and 3 -> d=1100, a single load pulse, and d=1010 held until then.
REQ-035 Back-to-back frames: 1010 then a start in the completing cycle with 0110 -> two load pulses 4 cycles apart; d=1010 then d=0110.
REQ-036 Abort: start+1,1, then start+0,0,1,1 -> frame_err=1, one load with d=0011; err_clr pulse -> frame_err=0.
REQ-037 Parity (SIPO_PARITY_EN): 1011 with parity bit 1 -> load, d=1011; 1011 with parity bit 0 -> no load, frame_err=1, d unchanged.
